// File: rtl/mux_reg_param_if.sv
// mux_reg_param_if: handshake/data bundle for mux_reg_param (paridade present only with MUX_PARITY_EN)
interface mux_reg_param_if #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int SEL_W = 2
);
    logic [N*W-1:0]   entradas;
    logic [SEL_W-1:0] controle;
    logic             modo;
    logic             entrada_valida;
    logic             entrada_pronta;
    logic [W-1:0]     saida;
    logic [SEL_W-1:0] canal;
    logic             saida_valida;
    logic             saida_pronta;
    logic             erro;
`ifdef MUX_PARITY_EN
    logic             paridade;
`endif

    modport slave (
        input  entradas, controle, modo, entrada_valida, saida_pronta,
        output entrada_pronta, saida, canal, saida_valida, erro
`ifdef MUX_PARITY_EN
        , output paridade
`endif
    );

    modport master (
        output entradas, controle, modo, entrada_valida, saida_pronta,
        input  entrada_pronta, saida, canal, saida_valida, erro
`ifdef MUX_PARITY_EN
        , input paridade
`endif
    );
endinterface

// File: rtl/mux_reg_param.sv
// mux_reg_param: N-channel W-bit selector, one output register with valid/ready; optional parity via MUX_PARITY_EN
module mux_reg_param #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int SEL_W = 2
)(
    input logic            clock,
    input logic            reset_n,
    mux_reg_param_if.slave bus
);
    logic [SEL_W-1:0] sel, ptr_q, ptr_d, canal_q, canal_d;
    logic [W-1:0]     dat, saida_q, saida_d;
    logic             load, oor, valid_q, valid_d, erro_q, erro_d;

    assign sel                = bus.modo ? ptr_q : bus.controle;
    assign oor                = 32'(sel) >= 32'(N);
    assign bus.entrada_pronta = !valid_q || bus.saida_pronta;
    assign load               = bus.entrada_valida && bus.entrada_pronta;
    assign bus.saida          = saida_q;
    assign bus.canal          = canal_q;
    assign bus.saida_valida   = valid_q;
    assign bus.erro           = erro_q;

    // channel mux; an index with no matching channel selects zero
    always_comb begin
        dat = '0;
        for (int i = 0; i < N; i++)
            if (sel == SEL_W'(i)) dat = bus.entradas[i*W +: W];
    end

    // next state: capture on load, drop valid on drain, round-robin pointer advances only on rr loads
    always_comb begin
        saida_d = load ? dat : saida_q;
        canal_d = load ? sel : canal_q;
        erro_d  = load ? oor : erro_q;
        valid_d = load || (valid_q && !bus.saida_pronta);
        ptr_d   = (load && bus.modo) ? ((ptr_q == SEL_W'(N-1)) ? '0 : ptr_q + 1'b1) : ptr_q;
    end

    // output stage and pointer registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saida_q <= '0;
            canal_q <= '0;
            valid_q <= 1'b0;
            erro_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            saida_q <= saida_d;
            canal_q <= canal_d;
            valid_q <= valid_d;
            erro_q  <= erro_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX_PARITY_EN
    logic par_q, par_d;

    assign par_d        = load ? ^dat : par_q;
    assign bus.paridade = par_q;

    // even parity of the held word, refreshed with every load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) par_q <= 1'b0;
        else          par_q <= par_d;
    end
`endif
endmodule

// File: tb/tb_mux_reg_param.sv
// tb_mux_reg_param: directed self-checking bench for mux_reg_param (N=4, W=16); parity checks with MUX_PARITY_EN
module tb_mux_reg_param;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mux_reg_param_if #(.N(4), .W(16), .SEL_W(2)) bus ();

    mux_reg_param #(.N(4), .W(16), .SEL_W(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] d, input logic [1:0] c, input logic v);
        chk({tag, ".saida"}, 32'(bus.saida), 32'(d));
        chk({tag, ".canal"}, 32'(bus.canal), 32'(c));
        chk({tag, ".valida"}, 32'(bus.saida_valida), 32'(v));
        chk({tag, ".erro"}, 32'(bus.erro), 32'd0);
    endtask

    logic [15:0] ch [4] = '{16'hA000, 16'hB001, 16'hC002, 16'hD003};
    logic [1:0]  seq5 [4] = '{2'd0, 2'd1, 2'd3, 2'd2};

    initial begin
        bus.entradas       = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        bus.controle       = 2'd0;
        bus.modo           = 1'b0;
        bus.entrada_valida = 1'b0;
        bus.saida_pronta   = 1'b0;

        #1 reset_n = 1'b0;
        #1;
        chk_out("reset", 16'h0000, 2'd0, 1'b0);
        chk("reset.pronta", 32'(bus.entrada_pronta), 32'd1);
`ifdef MUX_PARITY_EN
        chk("reset.paridade", 32'(bus.paridade), 32'd0);
`endif
        #10 reset_n = 1'b1;
        tick();
        chk("idle.valida", 32'(bus.saida_valida), 32'd0);

        bus.controle = 2'd2; bus.entrada_valida = 1'b1; bus.saida_pronta = 1'b1;
        tick();
        chk_out("ext2", 16'hC002, 2'd2, 1'b1);
        bus.entrada_valida = 1'b0; bus.controle = 2'd0;
        tick();
        chk_out("drain", 16'hC002, 2'd2, 1'b0);

        bus.controle = 2'd1; bus.entrada_valida = 1'b1; bus.saida_pronta = 1'b0;
        tick();
        chk_out("stall.load", 16'hB001, 2'd1, 1'b1);
        bus.controle = 2'd3;
        for (int k = 0; k < 3; k++) begin
            chk("stall.pronta", 32'(bus.entrada_pronta), 32'd0);
            tick();
            chk_out("stall.hold", 16'hB001, 2'd1, 1'b1);
        end
        bus.saida_pronta = 1'b1;
        #1;
        chk("release.pronta", 32'(bus.entrada_pronta), 32'd1);
        tick();
        chk_out("release.load", 16'hD003, 2'd3, 1'b1);

        bus.modo = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_out($sformatf("rr%0d", k), ch[k % 4], 2'(k % 4), 1'b1);
        end
        bus.entrada_valida = 1'b0;
        tick();
        chk("rr.drain", 32'(bus.saida_valida), 32'd0);

        bus.entrada_valida = 1'b1; bus.saida_pronta = 1'b0;
        tick();
        chk_out("pre_rst", 16'hC002, 2'd2, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        chk_out("mid_rst", 16'h0000, 2'd0, 1'b0);
        bus.saida_pronta = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            bus.modo = (k != 2);
            bus.controle = 2'd3;
            tick();
            chk_out($sformatf("mix%0d", k), ch[seq5[k]], seq5[k], 1'b1);
        end

`ifdef MUX_PARITY_EN
        bus.modo = 1'b0;
        bus.controle = 2'd3;
        tick();
        chk("par.d003", 32'(bus.paridade), 32'd1);
        bus.controle = 2'd0;
        tick();
        chk("par.a000", 32'(bus.paridade), 32'd0);
        bus.entrada_valida = 1'b0; bus.controle = 2'd3;
        tick();
        chk("par.hold", 32'(bus.paridade), 32'd0);
`endif

        bus.entrada_valida = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
